// File: rtl/bp_be_pkg.sv
// Shared types for the backend stride detector: processor config, FSM states,
// and the stride-table entry layout.
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg
    } bp_params_e;

    localparam int unsigned vaddr_width_gp = 39;
    localparam int unsigned conf_width_gp  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISCOVER,
        ST_CONFIRMED
    } sd_state_e;

    typedef struct packed {
        logic                      v;
        logic [vaddr_width_gp-1:0] pc;
        logic [vaddr_width_gp-1:0] last_addr;
        logic [vaddr_width_gp-1:0] stride;
        logic [conf_width_gp-1:0]  conf;
    } stride_entry_s;

    function automatic int unsigned bp_vaddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return vaddr_width_gp;
            default:          return vaddr_width_gp;
        endcase
    endfunction

endpackage

// File: rtl/bp_be_stride_table.sv
// Fully associative per-PC stride table with round-robin replacement;
// reports the post-update conf/stride of a hit and any valid entry evicted by a miss.
module bp_be_stride_table
    import bp_be_pkg::*;
#(
    parameter int unsigned entries_p = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      ld_v_i,
    input  logic [vaddr_width_gp-1:0] ld_pc_i,
    input  logic [vaddr_width_gp-1:0] ld_vaddr_i,
    output logic                      hit_o,
    output logic [conf_width_gp-1:0]  conf_o,
    output logic [vaddr_width_gp-1:0] stride_o,
    output logic                      evict_v_o,
    output logic [vaddr_width_gp-1:0] evict_pc_o
);

    localparam int unsigned idx_w = $clog2(entries_p);

    stride_entry_s             tbl_q [entries_p];
    stride_entry_s             tbl_d [entries_p];
    logic [idx_w-1:0]          ptr_q, ptr_d;

    logic [idx_w-1:0]          hit_idx, free_idx, victim_idx;
    logic                      free_v;
    logic [vaddr_width_gp-1:0] delta;
    stride_entry_s             hit_ent, new_ent;

    always_comb begin
        hit_o    = '0;
        hit_idx  = '0;
        free_v   = '0;
        free_idx = '0;
        for (int unsigned i = 0; i < entries_p; i++) begin
            if (tbl_q[i].v && tbl_q[i].pc == ld_pc_i) begin
                hit_o   = '1;
                hit_idx = idx_w'(i);
            end
            if (!tbl_q[i].v && !free_v) begin
                free_v   = '1;
                free_idx = idx_w'(i);
            end
        end
        victim_idx = free_v ? free_idx : ptr_q;

        hit_ent           = tbl_q[hit_idx];
        delta             = ld_vaddr_i - hit_ent.last_addr;
        new_ent           = hit_ent;
        new_ent.last_addr = ld_vaddr_i;
        if (delta == hit_ent.stride && delta != '0) begin
            new_ent.conf = (hit_ent.conf == '1) ? hit_ent.conf : hit_ent.conf + 1'b1;
        end else begin
            new_ent.stride = delta;
            new_ent.conf   = '0;
        end

        tbl_d = tbl_q;
        ptr_d = ptr_q;
        if (ld_v_i) begin
            if (hit_o) begin
                tbl_d[hit_idx] = new_ent;
            end else begin
                tbl_d[victim_idx] = '{v: 1'b1, pc: ld_pc_i, last_addr: ld_vaddr_i,
                                      stride: '0, conf: '0};
                ptr_d = victim_idx + 1'b1;
            end
        end

        conf_o     = new_ent.conf;
        stride_o   = new_ent.stride;
        evict_v_o  = ld_v_i && !hit_o && tbl_q[victim_idx].v;
        evict_pc_o = tbl_q[victim_idx].pc;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < entries_p; i++) begin
                tbl_q[i] <= '0;
            end
            ptr_q <= '0;
        end else begin
            tbl_q <= tbl_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bp_be_stride_detector.sv
// Detects a load PC with a steady address stride, opens a discovery for it,
// and confirms the stride once its confidence reaches the threshold.
module bp_be_stride_detector
    import bp_be_pkg::*;
#(
    parameter  bp_params_e  bp_params_p   = e_bp_default_cfg,
    localparam int unsigned vaddr_width_p = bp_vaddr_width(bp_params_p),
    parameter  int unsigned entries_p     = 4,
    parameter  int unsigned conf_thresh_p = 3,
    parameter  int unsigned timeout_p     = 255
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     ld_v_i,
    input  logic [vaddr_width_p-1:0] ld_pc_i,
    input  logic [vaddr_width_p-1:0] ld_vaddr_i,
    output logic                     start_discovery_o,
    output logic                     confirm_discovery_o,
    output logic [vaddr_width_p-1:0] striding_pc_o,
    output logic [vaddr_width_p-1:0] stride_o,
    input  logic                     loop_done_i
);

    logic                     tbl_hit, tbl_evict_v;
    logic [conf_width_gp-1:0] tbl_conf;
    logic [vaddr_width_p-1:0] tbl_stride, tbl_evict_pc;

    bp_be_stride_table #(
        .entries_p (entries_p)
    ) u_table (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .ld_v_i     (ld_v_i),
        .ld_pc_i    (ld_pc_i),
        .ld_vaddr_i (ld_vaddr_i),
        .hit_o      (tbl_hit),
        .conf_o     (tbl_conf),
        .stride_o   (tbl_stride),
        .evict_v_o  (tbl_evict_v),
        .evict_pc_o (tbl_evict_pc)
    );

    sd_state_e                state_q, state_d;
    logic [7:0]               tmo_q, tmo_d;
    logic [vaddr_width_p-1:0] spc_q, spc_d;
    logic [vaddr_width_p-1:0] stride_q, stride_d;
    logic                     start_q, start_d;
    logic                     confirm_q, confirm_d;
    logic                     pend_q, pend_d;
    logic                     on_pc;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        spc_d     = spc_q;
        stride_d  = stride_q;
        start_d   = '0;
        confirm_d = '0;
        pend_d    = '0;
        on_pc     = ld_v_i && tbl_hit && ld_pc_i == spc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ld_v_i && tbl_hit && tbl_conf == conf_width_gp'(1)) begin
                    spc_d   = ld_pc_i;
                    start_d = '1;
                    tmo_d   = '0;
                    // Threshold of one: confirm is deferred a cycle so start goes out first
                    if (conf_thresh_p == 1) begin
                        state_d  = ST_CONFIRMED;
                        stride_d = tbl_stride;
                        pend_d   = '1;
                    end else begin
                        state_d = ST_DISCOVER;
                    end
                end
            end
            ST_DISCOVER: begin
                if (ld_v_i) begin
                    tmo_d = tmo_q + 1'b1;
                    if (on_pc && tbl_conf == conf_width_gp'(conf_thresh_p)) begin
                        state_d   = ST_CONFIRMED;
                        stride_d  = tbl_stride;
                        confirm_d = '1;
                    end else if ((on_pc && tbl_conf == '0) ||
                                 (tbl_evict_v && tbl_evict_pc == spc_q) ||
                                 tmo_d == 8'(timeout_p)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CONFIRMED: begin
                confirm_d = pend_q;
                if (loop_done_i && !pend_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            spc_q     <= '0;
            stride_q  <= '0;
            start_q   <= '0;
            confirm_q <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            spc_q     <= spc_d;
            stride_q  <= stride_d;
            start_q   <= start_d;
            confirm_q <= confirm_d;
            pend_q    <= pend_d;
        end
    end

    assign start_discovery_o   = start_q;
    assign confirm_discovery_o = confirm_q;
    assign striding_pc_o       = spc_q;
    assign stride_o            = stride_q;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Directed bench for bp_be_stride_detector: default threshold instance plus a
// threshold-one instance sharing the same load stream.
module tb_bp_be_stride_detector;
    import bp_be_pkg::*;

    localparam int unsigned W = vaddr_width_gp;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         ld_v = 1'b0;
    logic [W-1:0] ld_pc = '0;
    logic [W-1:0] ld_vaddr = '0;
    logic         loop_done = 1'b0;

    logic         start, confirm, start1, confirm1;
    logic [W-1:0] spc, stride, spc1, stride1;

    int errors = 0;
    int checks = 0;
    int confirm_cnt = 0;
    int base_cnt;

    always #5 clk = ~clk;

    bp_be_stride_detector #(
        .bp_params_p   (e_bp_default_cfg),
        .entries_p     (4),
        .conf_thresh_p (3),
        .timeout_p     (255)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .ld_v_i              (ld_v),
        .ld_pc_i             (ld_pc),
        .ld_vaddr_i          (ld_vaddr),
        .start_discovery_o   (start),
        .confirm_discovery_o (confirm),
        .striding_pc_o       (spc),
        .stride_o            (stride),
        .loop_done_i         (loop_done)
    );

    bp_be_stride_detector #(
        .bp_params_p   (e_bp_default_cfg),
        .entries_p     (4),
        .conf_thresh_p (1),
        .timeout_p     (255)
    ) dut1 (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .ld_v_i              (ld_v),
        .ld_pc_i             (ld_pc),
        .ld_vaddr_i          (ld_vaddr),
        .start_discovery_o   (start1),
        .confirm_discovery_o (confirm1),
        .striding_pc_o       (spc1),
        .stride_o            (stride1),
        .loop_done_i         (loop_done)
    );

    always @(negedge clk) begin
        if (confirm) confirm_cnt++;
        assert (!(start && confirm) && !(start1 && confirm1)) else begin
            errors++;
            $error("FAIL pulse_excl: start=%0b confirm=%0b start1=%0b confirm1=%0b required no overlap",
                   start, confirm, start1, confirm1);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] pc, input logic [W-1:0] addr);
        ld_v = 1'b1;
        ld_pc = pc;
        ld_vaddr = addr;
        tick();
        ld_v = 1'b0;
    endtask

    // Reset for one edge with a load presented, which must be ignored.
    task automatic do_reset();
        reset_n = 1'b0;
        ld_v = 1'b1;
        ld_pc = W'(32'h100);
        ld_vaddr = W'(32'h1000);
        tick();
        reset_n = 1'b1;
        ld_v = 1'b0;
    endtask

    initial begin
        // Scenario 1: basic discovery and confirm, thresh-one instance alongside
        do_reset();
        check("rst_start", 64'(start), 64'd0);
        check("rst_confirm", 64'(confirm), 64'd0);
        check("rst_spc", 64'(spc), 64'd0);
        check("rst_stride", 64'(stride), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));

        load(W'(32'h100), W'(32'h1000));
        check("s1_start_a", 64'(start), 64'd0);
        load(W'(32'h100), W'(32'h1008));
        check("s1_start_b", 64'(start), 64'd0);
        load(W'(32'h100), W'(32'h1010));
        check("s1_start", 64'(start), 64'd1);
        check("s1_spc", 64'(spc), 64'h100);
        check("t1_start", 64'(start1), 64'd1);
        check("t1_confirm_early", 64'(confirm1), 64'd0);
        tick();
        check("s1_start_one_cycle", 64'(start), 64'd0);
        check("t1_confirm", 64'(confirm1), 64'd1);
        check("t1_start_off", 64'(start1), 64'd0);
        check("t1_stride", 64'(stride1), 64'd8);
        tick();
        check("t1_confirm_one_cycle", 64'(confirm1), 64'd0);

        load(W'(32'h100), W'(32'h1018));
        check("s1_confirm_early", 64'(confirm), 64'd0);
        load(W'(32'h100), W'(32'h1020));
        check("s1_confirm", 64'(confirm), 64'd1);
        check("s1_stride", 64'(stride), 64'd8);
        tick();
        check("s1_confirm_one_cycle", 64'(confirm), 64'd0);
        check("s1_state_conf", 64'(dut.state_q), 64'(ST_CONFIRMED));
        load(W'(32'h100), W'(32'h1040));
        check("s1_confirmed_quiet", 64'(start | confirm), 64'd0);
        check("s1_stride_held", 64'(stride), 64'd8);
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
        check("s1_idle_after_done", 64'(dut.state_q), 64'(ST_IDLE));

        // Scenario 2: stride change aborts discovery, then a fresh start from IDLE
        do_reset();
        load(W'(32'h200), W'(32'h2000));
        load(W'(32'h200), W'(32'h2010));
        load(W'(32'h200), W'(32'h2020));
        check("s2_start", 64'(start), 64'd1);
        base_cnt = confirm_cnt;
        load(W'(32'h200), W'(32'h2040));
        check("s2_abort_state", 64'(dut.state_q), 64'(ST_IDLE));
        check("s2_abort_no_start", 64'(start), 64'd0);
        check("s2_conf_zero", 64'(confirm), 64'd0);
        load(W'(32'h200), W'(32'h2060));
        check("s2_restart", 64'(start), 64'd1);
        check("s2_no_confirm", 64'(confirm_cnt - base_cnt), 64'd0);

        // Scenario 3: eviction of the discovering entry; loop_done ignored in DISCOVER
        do_reset();
        load(W'(32'h100), W'(32'h1000));
        load(W'(32'h100), W'(32'h1008));
        load(W'(32'h100), W'(32'h1010));
        check("s3_start", 64'(start), 64'd1);
        base_cnt = confirm_cnt;
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
        check("s3_done_ignored", 64'(dut.state_q), 64'(ST_DISCOVER));
        load(W'(32'h600), W'(32'h6000));
        load(W'(32'h700), W'(32'h7000));
        load(W'(32'h800), W'(32'h8000));
        check("s3_still_disc", 64'(dut.state_q), 64'(ST_DISCOVER));
        load(W'(32'h900), W'(32'h9000));
        check("s3_evict_abort", 64'(dut.state_q), 64'(ST_IDLE));
        load(W'(32'ha00), W'(32'ha000));
        check("s3_no_confirm", 64'(confirm_cnt - base_cnt), 64'd0);

        // Scenario 4: timeout after 255 unrelated loads
        do_reset();
        load(W'(32'h100), W'(32'h1000));
        load(W'(32'h100), W'(32'h1008));
        load(W'(32'h100), W'(32'h1010));
        check("s4_start", 64'(start), 64'd1);
        base_cnt = confirm_cnt;
        for (int i = 0; i < 254; i++) load(W'(32'h300), W'(32'h3000));
        check("s4_disc_at_254", 64'(dut.state_q), 64'(ST_DISCOVER));
        load(W'(32'h300), W'(32'h3000));
        check("s4_timeout", 64'(dut.state_q), 64'(ST_IDLE));
        check("s4_no_start", 64'(start), 64'd0);
        load(W'(32'h400), W'(32'h4000));
        load(W'(32'h400), W'(32'h4004));
        load(W'(32'h400), W'(32'h4008));
        check("s4_new_start", 64'(start), 64'd1);
        check("s4_new_spc", 64'(spc), 64'h400);
        check("s4_no_confirm", 64'(confirm_cnt - base_cnt), 64'd0);

        // Scenario 5: reset while CONFIRMED
        do_reset();
        for (int i = 0; i < 5; i++) load(W'(32'h100), W'(32'h1000 + 8 * i));
        check("s5_confirm", 64'(confirm), 64'd1);
        tick();
        do_reset();
        check("s5_start", 64'(start), 64'd0);
        check("s5_confirm_off", 64'(confirm), 64'd0);
        check("s5_spc", 64'(spc), 64'd0);
        check("s5_stride", 64'(stride), 64'd0);
        check("s5_state", 64'(dut.state_q), 64'(ST_IDLE));
        for (int i = 0; i < 4; i++) check("s5_tbl_empty", 64'(dut.u_table.tbl_q[i].v), 64'd0);
        load(W'(32'h100), W'(32'h1000));
        load(W'(32'h100), W'(32'h1008));
        check("s5_rep_no_start", 64'(start), 64'd0);
        load(W'(32'h100), W'(32'h1010));
        check("s5_rep_start", 64'(start), 64'd1);
        check("s5_rep_spc", 64'(spc), 64'h100);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
